ppi_rx_packer: RTL and testbench

- Drains a show-ahead (FWFT) RX byte FIFO and packs LANES consecutive bytes into one wide word.
- Presents each word on a valid/ready stream with per-lane byte enables.
- Detects idle (a run of IDLE_LEN zero bytes). In drop mode it flushes the partial word, then discards further zero bytes until traffic resumes.
- Sits between the HS RX FIFO read side and the downstream packet layer.

---
 rtl/ppi_rx_packer.sv | 151 +++++++++++++++
 tb/tb_ppi_rx_packer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppi_rx_packer.sv
// ppi_rx_packer: drains a show-ahead RX byte FIFO, packs LANES bytes per word
// and presents the words on a valid/ready stream. A run of IDLE_LEN zero
// bytes marks idle; in drop mode the partial word is flushed with m_last and
// further zero bytes are discarded until a nonzero byte arrives.
module ppi_rx_packer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LANES      = 4,
  parameter int unsigned IDLE_LEN   = 24
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_WIDTH-1:0]       r_data,
  input  logic                        o_empty,
  output logic                        rinc,
  input  logic                        en,
  input  logic                        drop_idle,
  output logic [LANES*DATA_WIDTH-1:0] m_data,
  output logic [LANES-1:0]            m_keep,
  output logic                        m_last,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic                        idle,
  output logic [15:0]                 drop_cnt
);

  localparam int unsigned ACW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned ZRW = $clog2(IDLE_LEN + 1);

  typedef enum logic {ST_ACTIVE, ST_IDLE} state_t;

  state_t state_q, state_d;

  logic [LANES-1:0][DATA_WIDTH-1:0] acc_q, acc_d, word;
  logic [LANES-1:0]                 keep;
  logic [ACW-1:0]                   acc_cnt_q, acc_cnt_d;
  logic [ZRW-1:0]                   zero_run_q, zero_run_d, zr_inc;
  logic [15:0]                      drop_cnt_q, drop_cnt_d;

  logic [LANES*DATA_WIDTH-1:0]      m_data_q;
  logic [LANES-1:0]                 m_keep_q;
  logic                             m_last_q;
  logic                             m_valid_q;

  logic byte_zero, lane_full, idle_hit, discard, emit_if, out_free, accept, load;

  // Per-byte decode: what the head byte would do if it were accepted now.
  always_comb begin
    byte_zero = (r_data == '0);
    zr_inc    = (zero_run_q == ZRW'(IDLE_LEN)) ? zero_run_q : zero_run_q + 1'b1;
    lane_full = (acc_cnt_q == ACW'(LANES - 1));
    idle_hit  = drop_idle & byte_zero & (zr_inc == ZRW'(IDLE_LEN));
    discard   = (state_q == ST_IDLE) & byte_zero;
    // acc_cnt is 0 in IDLE, so lane_full there only holds for single-lane words
    emit_if   = (state_q == ST_ACTIVE) ? (lane_full | idle_hit) : (!byte_zero & lane_full);
    out_free  = !m_valid_q | m_ready;
    rinc      = rst & en & !o_empty & (!emit_if | out_free);
    accept    = rinc;
    load      = accept & emit_if;
  end

  // Word as it would look with the head byte in lane acc_cnt; unfilled lanes read zero.
  always_comb begin
    word = '0;
    keep = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (ACW'(i) == acc_cnt_q)     word[i] = r_data;
      else if (ACW'(i) < acc_cnt_q) word[i] = acc_q[i];
      keep[i] = (ACW'(i) <= acc_cnt_q);
    end
  end

  // Accumulator, zero-run and drop-counter next state.
  always_comb begin
    acc_d      = acc_q;
    acc_cnt_d  = acc_cnt_q;
    zero_run_d = zero_run_q;
    drop_cnt_d = drop_cnt_q;
    if (accept) begin
      if (discard) begin
        drop_cnt_d = (drop_cnt_q == 16'hFFFF) ? drop_cnt_q : drop_cnt_q + 16'd1;
      end else if (state_q == ST_ACTIVE) begin
        acc_d      = word;
        acc_cnt_d  = emit_if ? '0 : acc_cnt_q + 1'b1;
        zero_run_d = byte_zero ? zr_inc : '0;
      end else begin
        acc_d      = word;
        acc_cnt_d  = emit_if ? '0 : ACW'(1);
        zero_run_d = '0;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q      <= '0;
      acc_cnt_q  <= '0;
      zero_run_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      acc_q      <= acc_d;
      acc_cnt_q  <= acc_cnt_d;
      zero_run_q <= zero_run_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Output word register: load on emit, otherwise hold until accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_data_q  <= '0;
      m_keep_q  <= '0;
      m_last_q  <= 1'b0;
      m_valid_q <= 1'b0;
    end else if (load) begin
      m_data_q  <= word;
      m_keep_q  <= keep;
      m_last_q  <= (state_q == ST_ACTIVE) & idle_hit;
      m_valid_q <= 1'b1;
    end else if (m_ready) begin
      m_valid_q <= 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_ACTIVE;
    else      state_q <= state_d;
  end

  // FSM next state: enter IDLE on the flushing zero, leave on any nonzero byte.
  always_comb begin
    state_d = state_q;
    if (accept) begin
      if (state_q == ST_ACTIVE && idle_hit)      state_d = ST_IDLE;
      else if (state_q == ST_IDLE && !byte_zero) state_d = ST_ACTIVE;
    end
  end

  // FSM outputs: idle status follows the state in drop mode, the zero run otherwise.
  always_comb begin
    idle = drop_idle ? (state_q == ST_IDLE) : (zero_run_q == ZRW'(IDLE_LEN));
  end

  assign m_data   = m_data_q;
  assign m_keep   = m_keep_q;
  assign m_last   = m_last_q;
  assign m_valid  = m_valid_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_ppi_rx_packer.sv
// Scoreboard bench for ppi_rx_packer: a queue-modelled FWFT FIFO feeds the DUT,
// expected words are queued with the stimulus and checked by a monitor.
module tb_ppi_rx_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  r_data;
  logic        o_empty;
  logic        rinc;
  logic        en;
  logic        drop_idle;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        m_last;
  logic        m_valid;
  logic        m_ready;
  logic        idle;
  logic [15:0] drop_cnt;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } word_t;

  word_t      exp_q[$];
  logic [7:0] fifo[$];
  int         tests = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  ppi_rx_packer #(.DATA_WIDTH(8), .LANES(4), .IDLE_LEN(24)) dut (
    .clk(clk), .rst(rst), .r_data(r_data), .o_empty(o_empty), .rinc(rinc),
    .en(en), .drop_idle(drop_idle), .m_data(m_data), .m_keep(m_keep),
    .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready), .idle(idle),
    .drop_cnt(drop_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_word(input logic [31:0] d, input logic [3:0] k, input logic l);
    word_t w;
    w.d = d;
    w.k = k;
    w.l = l;
    exp_q.push_back(w);
  endtask

  task automatic push_n(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) fifo.push_back(b);
  endtask

  task automatic wait_empty(input int budget, input string name);
    int n;
    n = 0;
    while (fifo.size() != 0 && n < budget) begin
      tick(1);
      n++;
    end
    if (fifo.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL %s_drain: %0d bytes left, expected 0", name, fifo.size());
    end
    tick(3);
  endtask

  // FIFO model: pop on the edge where rinc was high, then present the new head.
  initial begin
    logic p;
    r_data  = 8'h00;
    o_empty = 1'b1;
    forever begin
      @(posedge clk);
      p = rinc;
      #2;
      if (p) begin
        check("pop_nonempty", 32'(fifo.size() > 0), 32'd1);
        if (fifo.size() > 0) void'(fifo.pop_front());
      end
      r_data  = (fifo.size() > 0) ? fifo[0] : 8'h00;
      o_empty = (fifo.size() == 0);
    end
  end

  // Monitor: every transfer is checked against the head of the scoreboard.
  always @(negedge clk) begin
    word_t w;
    if (rst && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_word: got 0x%0h keep %b last %b, expected none", m_data, m_keep, m_last);
      end else begin
        w = exp_q.pop_front();
        check("word_data", m_data, w.d);
        check("word_keep", 32'(m_keep), 32'(w.k));
        check("word_last", 32'(m_last), 32'(w.l));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int cnt;
    en        = 1'b0;
    drop_idle = 1'b0;
    m_ready   = 1'b0;

    // Reset state, with data waiting in the FIFO and en high
    en = 1'b1;
    fifo.push_back(8'h77);
    tick(2);
    @(negedge clk);
    check("rst_rinc",     32'(rinc),     32'd0);
    check("rst_m_valid",  32'(m_valid),  32'd0);
    check("rst_m_data",   m_data,        32'd0);
    check("rst_m_keep",   32'(m_keep),   32'd0);
    check("rst_m_last",   32'(m_last),   32'd0);
    check("rst_idle",     32'(idle),     32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    en = 1'b0;
    fifo.delete();
    tick(2);
    rst = 1'b1;
    tick(1);

    // Full-rate packing, two words
    m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) fifo.push_back(8'(i));
    expect_word(32'h04030201, 4'b1111, 1'b0);
    expect_word(32'h08070605, 4'b1111, 1'b0);
    tick(1);
    en  = 1'b1;
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (rinc) cnt++;
    end
    check("rinc_run", 32'(cnt), 32'd8);
    wait_empty(20, "t1");

    // Backpressure with the next word one byte from complete
    m_ready = 1'b0;
    for (int i = 1; i <= 8; i++) fifo.push_back(8'(i));
    expect_word(32'h04030201, 4'b1111, 1'b0);
    expect_word(32'h08070605, 4'b1111, 1'b0);
    tick(12);
    @(negedge clk);
    check("stall_rinc",    32'(rinc),        32'd0);
    check("stall_m_valid", 32'(m_valid),     32'd1);
    check("stall_m_data",  m_data,           32'h04030201);
    check("stall_fifo",    32'(fifo.size()), 32'd1);
    tick(1);
    m_ready = 1'b1;
    wait_empty(20, "t2");

    // Idle drop: AA, 24 zeros, 5 zeros, then BB 01 02 03
    drop_idle = 1'b1;
    fifo.push_back(8'hAA);
    push_n(8'h00, 24);
    expect_word(32'h000000AA, 4'b1111, 1'b0);
    for (int i = 0; i < 5; i++) expect_word(32'h0, 4'b1111, 1'b0);
    expect_word(32'h0, 4'b0001, 1'b1);
    wait_empty(60, "t3a");
    check("drop_idle_entered", 32'(idle),     32'd1);
    check("drop_cnt_before",   32'(drop_cnt), 32'd0);
    push_n(8'h00, 5);
    wait_empty(20, "t3b");
    check("drop_idle_held",    32'(idle),     32'd1);
    check("drop_cnt_5",        32'(drop_cnt), 32'd5);
    fifo.push_back(8'hBB);
    fifo.push_back(8'h01);
    fifo.push_back(8'h02);
    fifo.push_back(8'h03);
    expect_word(32'h030201BB, 4'b1111, 1'b0);
    wait_empty(20, "t3c");
    check("drop_idle_exit",    32'(idle),        32'd0);
    check("drop_sb_empty",     32'(exp_q.size()), 32'd0);

    // Forward mode: same pattern, every byte forwarded
    drop_idle = 1'b0;
    fifo.push_back(8'hAA);
    push_n(8'h00, 23);
    expect_word(32'h000000AA, 4'b1111, 1'b0);
    for (int i = 0; i < 5; i++) expect_word(32'h0, 4'b1111, 1'b0);
    wait_empty(60, "t4a");
    check("fwd_idle_23", 32'(idle), 32'd0);
    push_n(8'h00, 1);
    wait_empty(20, "t4b");
    check("fwd_idle_24", 32'(idle), 32'd1);
    push_n(8'h00, 5);
    expect_word(32'h0, 4'b1111, 1'b0);
    wait_empty(20, "t4c");
    check("fwd_idle_29",  32'(idle),     32'd1);
    check("fwd_drop_cnt", 32'(drop_cnt), 32'd5);
    fifo.push_back(8'hBB);
    fifo.push_back(8'hCC);
    expect_word(32'hCCBB0000, 4'b1111, 1'b0);
    wait_empty(20, "t4d");
    check("fwd_idle_exit", 32'(idle),         32'd0);
    check("fwd_sb_empty",  32'(exp_q.size()), 32'd0);

    // Reset mid-word with a pending output word
    m_ready = 1'b0;
    for (int i = 1; i <= 4; i++) fifo.push_back(8'(i));
    fifo.push_back(8'h11);
    fifo.push_back(8'h22);
    wait_empty(20, "t5a");
    check("pre_rst_m_valid", 32'(m_valid), 32'd1);
    rst = 1'b0;
    fifo.push_back(8'h11);
    fifo.push_back(8'h22);
    fifo.push_back(8'h33);
    fifo.push_back(8'h44);
    tick(2);
    @(negedge clk);
    check("mid_rst_m_valid", 32'(m_valid), 32'd0);
    check("mid_rst_rinc",    32'(rinc),    32'd0);
    tick(1);
    rst     = 1'b1;
    m_ready = 1'b1;
    expect_word(32'h44332211, 4'b1111, 1'b0);
    wait_empty(20, "t5b");
    check("post_rst_drop_cnt", 32'(drop_cnt), 32'd0);

    // en low: no pops, pending word still drains
    m_ready = 1'b0;
    for (int i = 1; i <= 4; i++) fifo.push_back(8'(i));
    expect_word(32'h04030201, 4'b1111, 1'b0);
    wait_empty(20, "t6a");
    check("en_pending", 32'(m_valid), 32'd1);
    en = 1'b0;
    for (int i = 5; i <= 8; i++) fifo.push_back(8'(i));
    expect_word(32'h08070605, 4'b1111, 1'b0);
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (rinc) cnt++;
    end
    check("en0_rinc", 32'(cnt),         32'd0);
    check("en0_fifo", 32'(fifo.size()), 32'd4);
    tick(1);
    m_ready = 1'b1;
    tick(3);
    @(negedge clk);
    check("en0_drained", 32'(m_valid), 32'd0);
    tick(1);
    en = 1'b1;
    wait_empty(20, "t6b");
    check("final_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
